// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a 2**AW-byte register file and a local register-write strobe.
// Ports: clk system clock (>= 8x SCL); rstn async active-low reset; scl_i/sda_i raw bus inputs;
//        sda_oe 1 pulls SDA low (open drain); busy high from matched address until STOP/START;
//        wr_stb one-clk pulse per register write with wr_addr/wr_data.
// Build option: I2C_TGT_AUTOINC_EN advances the register pointer after each written or ACKed read byte.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h57,
    parameter int         AW       = 4,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);
`ifdef I2C_TGT_AUTOINC_EN
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
`else
    localparam logic [AW-1:0] PTR_STEP = '0;
`endif
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IDLE_WAIT} state_t;
    state_t        state_q, state_d;
    logic [2:0]    scl_q, scl_d, sda_q, sda_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, wr_data_q, wr_data_d;
    logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic          rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, wr_stb_q, wr_stb_d;
    logic [7:0]    regs_q [2**AW];
    logic [7:0]    regs_d [2**AW];
    logic          scl_rise, scl_fall, start_c, stop_c, byte_done;
    logic [7:0]    byte_in, rd_byte;
    // bit [1] is the synchronised level, bit [2] the previous sample for edge detection
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_c   = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_c    = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign byte_in   = {shift_q[6:0], sda_q[1]};
    assign byte_done = scl_rise && bit_cnt_q == 4'd7;
    assign rd_byte   = regs_q[ptr_q];
    always_comb begin
        scl_d     = {scl_q[1:0], scl_i};
        sda_d     = {sda_q[1:0], sda_i};
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        regs_d    = regs_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (byte_done) begin
                    state_d = byte_in[7:1] == TGT_ADDR ? ADDR_ACK : IDLE;
                    busy_d  = byte_in[7:1] == TGT_ADDR;
                    rw_d    = byte_in[0];
                end
                PTR: if (byte_done) begin
                    ptr_d   = byte_in[AW-1:0];
                    state_d = PTR_ACK;
                end
                WDATA: if (byte_done) begin
                    regs_d[ptr_q] = byte_in;
                    wr_stb_d      = 1'b1;
                    wr_addr_d     = ptr_q;
                    wr_data_d     = byte_in;
                    ptr_d         = ptr_q + PTR_STEP;
                    state_d       = WDATA_ACK;
                end
                // receivers never drive SDA, so the first fall opens the ack slot and the next closes it
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe_q) sda_oe_d = 1'b1;
                    else begin
                        bit_cnt_d = '0;
                        state_d   = state_q == ADDR_ACK ? (rw_q ? RDATA : PTR) : WDATA;
                        shift_d   = rd_byte;
                        sda_oe_d  = state_q == ADDR_ACK && rw_q && !rd_byte[7];
                    end
                end
                RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = bit_cnt_q != 4'd8 && !shift_q[6];
                        if (bit_cnt_q == 4'd8) state_d = RACK;
                    end
                end
                // bit_cnt 9 marks an ACKed byte waiting for the SCL fall to present the next one
                RACK: begin
                    if (scl_rise) begin
                        state_d   = sda_q[1] ? IDLE_WAIT : RACK;
                        ptr_d     = sda_q[1] ? ptr_q : ptr_q + PTR_STEP;
                        bit_cnt_d = 4'd9;
                    end
                    if (scl_fall && bit_cnt_q == 4'd9) begin
                        shift_d   = rd_byte;
                        sda_oe_d  = !rd_byte[7];
                        bit_cnt_d = '0;
                        state_d   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            scl_q     <= '1;
            sda_q     <= '1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            regs_q    <= '{default: RST_VAL};
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level controller model driving i2c_target_regs against a register-file reference model.
module tb_i2c_target_regs;
`ifdef I2C_TGT_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif
    logic        clk = 1'b0, rstn = 1'b0, scl = 1'b1, sda_m = 1'b1;
    logic        sda_oe, busy, wr_stb;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    wire         sda = sda_m & ~sda_oe;
    int          checks = 0, passed = 0, oe_cnt = 0, obs_rd = 0, mptr = 0;
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    logic [7:0]  mreg [16];
    logic [7:0]  wbuf [8];

    i2c_target_regs dut (
        .clk(clk), .rstn(rstn), .scl_i(scl), .sda_i(sda), .sda_oe(sda_oe),
        .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #10ms;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic bit_xfer(input logic b, output logic r);
        repeat (5) @(negedge clk); sda_m = b;
        repeat (5) @(negedge clk); scl = 1'b1;
        repeat (5) @(negedge clk); r = sda;
        repeat (5) @(negedge clk); scl = 1'b0;
    endtask

    task automatic do_start;
        repeat (5) @(negedge clk); sda_m = 1'b1;
        repeat (5) @(negedge clk); scl = 1'b1;
        repeat (5) @(negedge clk); sda_m = 1'b0;
        repeat (5) @(negedge clk); scl = 1'b0;
    endtask

    task automatic do_stop;
        repeat (5) @(negedge clk); sda_m = 1'b0;
        repeat (5) @(negedge clk); scl = 1'b1;
        repeat (5) @(negedge clk); sda_m = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nack, r);
    endtask

    task automatic wr_xact(input logic [7:0] pb, input int n, input string tag);
        logic ack;
        logic [11:0] got;
        do_start;
        send_byte(8'hAE, ack);
        checks++; if (ack !== 1'b1) $display("FAIL %s addr_ack got %b exp 1", tag, ack); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL %s busy_match got %b exp 1", tag, busy); else passed++;
        send_byte(pb, ack);
        checks++; if (ack !== 1'b1) $display("FAIL %s ptr_ack got %b exp 1", tag, ack); else passed++;
        mptr = int'(pb[3:0]);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            checks++; if (ack !== 1'b1) $display("FAIL %s data_ack%0d got %b exp 1", tag, i, ack); else passed++;
            mreg[mptr] = wbuf[i];
            exp_q.push_back({4'(mptr), wbuf[i]});
            mptr = (mptr + INC) % 16;
        end
        do_stop;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy_stop got %b exp 0", tag, busy); else passed++;
        checks++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL %s stb_count got %0d exp %0d", tag, obs_q.size() - obs_rd, exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            got = obs_q[obs_rd];
            obs_rd++;
            checks++;
            if (got !== exp_q[0]) $display("FAIL %s stb addr/data got %h exp %h", tag, got, exp_q[0]);
            else passed++;
            void'(exp_q.pop_front());
        end
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic rd_xact(input logic set_ptr, input logic [3:0] p, input int n, input string tag);
        logic ack;
        logic [7:0] d;
        do_start;
        if (set_ptr) begin
            send_byte(8'hAE, ack);
            checks++; if (ack !== 1'b1) $display("FAIL %s waddr_ack got %b exp 1", tag, ack); else passed++;
            send_byte({4'($urandom), p}, ack);
            checks++; if (ack !== 1'b1) $display("FAIL %s ptr_ack got %b exp 1", tag, ack); else passed++;
            mptr = int'(p);
            do_start;
        end
        send_byte(8'hAF, ack);
        checks++; if (ack !== 1'b1) $display("FAIL %s raddr_ack got %b exp 1", tag, ack); else passed++;
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            checks++;
            if (d !== mreg[mptr]) $display("FAIL %s rdata%0d reg %0d got %h exp %h", tag, i, mptr, d, mreg[mptr]);
            else passed++;
            if (i != n - 1) mptr = (mptr + INC) % 16;
        end
        repeat (5) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) $display("FAIL %s release_after_nack got %b exp 0", tag, sda_oe); else passed++;
        do_stop;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy_stop got %b exp 0", tag, busy); else passed++;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b exp 0", sda_oe); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
        checks++; if (wr_stb !== 1'b0) $display("FAIL reset_wr_stb got %b exp 0", wr_stb); else passed++;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        rd_xact(1'b0, 4'h0, 1, "reset_read");
    endtask

    task automatic test_write;
        wbuf[0] = 8'h55;
        wr_xact(8'h03, 1, "write");
    endtask

    task automatic test_read_sr;
        rd_xact(1'b1, 4'h3, 1, "read_sr");
    endtask

    task automatic test_mismatch;
        logic ack;
        int base;
        base = oe_cnt;
        do_start;
        send_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) $display("FAIL mismatch_ack got %b exp 0", ack); else passed++;
        send_byte(8'($urandom), ack);
        send_byte(8'($urandom), ack);
        checks++; if (busy !== 1'b0) $display("FAIL mismatch_busy got %b exp 0", busy); else passed++;
        do_stop;
        checks++; if (oe_cnt !== base) $display("FAIL mismatch_sda_oe driven %0d clks exp 0", oe_cnt - base); else passed++;
        checks++;
        if (obs_q.size() !== obs_rd) $display("FAIL mismatch_stb got %0d exp 0", obs_q.size() - obs_rd);
        else passed++;
        obs_rd = obs_q.size();
    endtask

    task automatic test_wrap;
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wr_xact(8'h0F, 2, "wrap");
        rd_xact(1'b1, 4'hF, 2, "wrap_read");
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            wr_xact(8'($urandom), n, "rand_wr");
            rd_xact(1'($urandom), 4'($urandom), $urandom_range(1, 4), "rand_rd");
        end
    endtask

    task automatic test_abort;
        logic ack, r;
        do_start;
        send_byte(8'hAE, ack);
        send_byte(8'h07, ack);
        mptr = 7;
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), r);
        do_stop;
        checks++;
        if (obs_q.size() !== obs_rd) $display("FAIL abort_stb got %0d exp 0", obs_q.size() - obs_rd);
        else passed++;
        obs_rd = obs_q.size();
        rd_xact(1'b1, 4'h7, 1, "abort_read");
        wbuf[0] = 8'h00;
        wr_xact(8'h05, 1, "zero_wr");
        do_start;
        send_byte(8'hAE, ack);
        send_byte(8'h05, ack);
        do_start;
        send_byte(8'hAF, ack);
        bit_xfer(1'b1, r);
        bit_xfer(1'b1, r);
        repeat (4) @(negedge clk);
        checks++; if (sda_oe !== 1'b1) $display("FAIL rdata_drive got %b exp 1", sda_oe); else passed++;
        rstn = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL reset_release got %b exp 0", sda_oe); else passed++;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        do_stop;
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        mptr = 0;
        obs_rd = obs_q.size();
        rd_xact(1'b0, 4'h0, 1, "post_reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
        test_reset;
        test_write;
        test_read_sr;
        test_mismatch;
        test_wrap;
        test_random;
        test_abort;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
